// File: rtl/store_buffer.sv
// store_buffer: in-order store FIFO between a CPU store port and data memory,
// with load-to-store forwarding and a flush (drain) state machine.
//
// Ports:
//   clk, reset                      clock; asynchronous active-high reset
//   st_req, st_addr, st_data, st_pc store request and its payload
//   st_ready                        a store can be accepted this cycle
//   ld_addr, ld_hit, ld_data        forwarding lookup (youngest match wins)
//   flush, flush_done               drain request; one-cycle completion pulse
//   dm_we, dm_addr, dm_wdata, dm_pc head entry presented to data memory
//   dm_ready                        data memory accepts the head entry
//   count                           number of valid entries
//   overflow                        sticky: a store was dropped
module store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_req,
  input  logic [31:0]              st_addr,
  input  logic [31:0]              st_data,
  input  logic [31:0]              st_pc,
  output logic                     st_ready,
  input  logic [31:0]              ld_addr,
  output logic                     ld_hit,
  output logic [31:0]              ld_data,
  input  logic                     flush,
  output logic                     flush_done,
  output logic                     dm_we,
  output logic [31:0]              dm_addr,
  output logic [31:0]              dm_wdata,
  output logic [31:0]              dm_pc,
  input  logic                     dm_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_DRAIN = 1'b1;

  logic [29:0]   addr_mem [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [0:0]    state;
  logic [0:0]    next_state;
  logic          flush_done_d;
  logic          push;
  logic          pop;
  logic [PW-1:0] fwd_idx;

  // Byte-offset bits of the addresses play no part in word matching.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{st_addr[1:0], ld_addr[1:0]};

  // Handshakes; st_ready is held low while reset is asserted.
  assign st_ready = ~reset & (count < CW'(DEPTH)) & (state == S_IDLE);
  assign push     = st_req & st_ready;
  assign dm_we    = (count != '0);
  assign pop      = dm_we & dm_ready;

  // Head entry to data memory, zero when empty.
  assign dm_addr  = dm_we ? {addr_mem[head], 2'b00} : 32'h0;
  assign dm_wdata = dm_we ? data_mem[head] : 32'h0;
  assign dm_pc    = dm_we ? pc_mem[head]   : 32'h0;

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (st_req && !st_ready) overflow <= 1'b1;
    end
  end

  // Entry storage; validity is tracked by head/count, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail] <= st_addr[31:2];
      data_mem[tail] <= st_data;
      pc_mem[tail]   <= st_pc;
    end
  end

  // Forwarding: walk oldest to youngest so the youngest match is kept last.
  always_comb begin
    ld_hit  = 1'b0;
    ld_data = 32'h0;
    fwd_idx = head;
    for (int i = 0; i < int'(DEPTH); i++) begin
      fwd_idx = head + PW'(i);
      if ((CW'(i) < count) && (addr_mem[fwd_idx] == ld_addr[31:2])) begin
        ld_hit  = 1'b1;
        ld_data = data_mem[fwd_idx];
      end
    end
  end

  // Flush state register and registered completion pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      flush_done <= 1'b0;
    end else begin
      state      <= next_state;
      flush_done <= flush_done_d;
    end
  end

  // Flush next-state logic; a re-asserted flush in DRAIN has no effect.
  always_comb begin
    next_state   = state;
    flush_done_d = 1'b0;
    case (state)
      S_IDLE: begin
        if (flush) next_state = S_DRAIN;
      end
      S_DRAIN: begin
        if (count == '0) begin
          next_state   = S_IDLE;
          flush_done_d = 1'b1;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

  logic        clk;
  logic        reset;
  logic        st_req;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [31:0] st_pc;
  logic        st_ready;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic        flush;
  logic        flush_done;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_pc;
  logic        dm_ready;
  logic [2:0]  count;
  logic        overflow;

  int n_cmp;
  int n_err;

  store_buffer #(.DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .st_req     (st_req),
    .st_addr    (st_addr),
    .st_data    (st_data),
    .st_pc      (st_pc),
    .st_ready   (st_ready),
    .ld_addr    (ld_addr),
    .ld_hit     (ld_hit),
    .ld_data    (ld_data),
    .flush      (flush),
    .flush_done (flush_done),
    .dm_we      (dm_we),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_pc      (dm_pc),
    .dm_ready   (dm_ready),
    .count      (count),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [31:0] p);
    st_req  = 1'b1;
    st_addr = a;
    st_data = d;
    st_pc   = p;
    step();
    st_req  = 1'b0;
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    reset    = 1'b1;
    st_req   = 1'b0;
    st_addr  = 32'h0;
    st_data  = 32'h0;
    st_pc    = 32'h0;
    ld_addr  = 32'h0;
    flush    = 1'b0;
    dm_ready = 1'b0;

    // Reset state
    #3;
    chk("rst_count",    32'(count),      32'd0);
    chk("rst_st_ready", 32'(st_ready),   32'd0);
    chk("rst_dm_we",    32'(dm_we),      32'd0);
    chk("rst_ld_hit",   32'(ld_hit),     32'd0);
    chk("rst_overflow", 32'(overflow),   32'd0);
    chk("rst_fdone",    32'(flush_done), 32'd0);
    #9 reset = 1'b0;
    step();
    chk("post_rst_st_ready", 32'(st_ready), 32'd1);

    // Single push, held, then written
    push(32'h10, 32'hAAAA0001, 32'h100);
    #1;
    chk("t1_count",  32'(count),  32'd1);
    chk("t1_dm_we",  32'(dm_we),  32'd1);
    chk("t1_addr",   dm_addr,     32'h10);
    chk("t1_wdata",  dm_wdata,    32'hAAAA0001);
    chk("t1_pc",     dm_pc,       32'h100);
    dm_ready = 1'b1;
    step();
    dm_ready = 1'b0;
    #1;
    chk("t1_count_after", 32'(count), 32'd0);
    chk("t1_dm_we_after", 32'(dm_we), 32'd0);
    chk("t1_addr_empty",  dm_addr,    32'h0);

    // Forwarding: youngest match, byte offset ignored, miss gives zero
    push(32'h20, 32'h1, 32'h200);
    push(32'h20, 32'h2, 32'h204);
    ld_addr = 32'h23;
    #1;
    chk("fwd_hit",   32'(ld_hit), 32'd1);
    chk("fwd_data",  ld_data,     32'h2);
    ld_addr = 32'h24;
    #1;
    chk("fwd_miss_hit",  32'(ld_hit), 32'd0);
    chk("fwd_miss_data", ld_data,     32'h0);
    chk("fwd_head_old",  dm_wdata,    32'h1);
    dm_ready = 1'b1;
    step();
    // Entry being popped stays visible this cycle
    ld_addr = 32'h20;
    #1;
    chk("fwd_popping_hit",  32'(ld_hit), 32'd1);
    chk("fwd_popping_data", ld_data,     32'h2);
    step();
    dm_ready = 1'b0;
    #1;
    chk("fwd_gone_hit", 32'(ld_hit), 32'd0);
    // Store pushed this cycle is not yet visible
    st_req  = 1'b1;
    st_addr = 32'h30;
    st_data = 32'h33;
    ld_addr = 32'h30;
    #1;
    chk("fwd_same_cycle", 32'(ld_hit), 32'd0);
    step();
    st_req = 1'b0;
    #1;
    chk("fwd_next_cycle", ld_data, 32'h33);
    dm_ready = 1'b1;
    step();
    dm_ready = 1'b0;

    // Fill, overflow, drain in push order
    for (int i = 0; i < 4; i++) push(32'h40 + 32'(4 * i), 32'h100 + 32'(i), 32'h0);
    #1;
    chk("full_count",    32'(count),    32'd4);
    chk("full_st_ready", 32'(st_ready), 32'd0);
    push(32'h80, 32'hDEAD, 32'h0);
    #1;
    chk("ovf_flag",  32'(overflow), 32'd1);
    chk("ovf_count", 32'(count),    32'd4);
    dm_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_wdata", dm_wdata, 32'h100 + 32'(i));
      chk("drain_addr",  dm_addr,  32'h40 + 32'(4 * i));
      step();
    end
    dm_ready = 1'b0;
    #1;
    chk("drain_count",  32'(count),    32'd0);
    chk("ovf_sticky",   32'(overflow), 32'd1);

    // Full with simultaneous pop: push refused, then push+pop with wrap
    for (int i = 0; i < 4; i++) push(32'h60 + 32'(4 * i), 32'h200 + 32'(i), 32'h0);
    dm_ready = 1'b1;
    st_req   = 1'b1;
    st_addr  = 32'h90;
    st_data  = 32'h2FF;
    #1;
    chk("wrap_refused_ready", 32'(st_ready), 32'd0);
    step();
    chk("wrap_count3", 32'(count), 32'd3);
    chk("wrap_head1",  dm_wdata,   32'h201);
    st_addr = 32'h94;
    st_data = 32'h300;
    #1;
    chk("wrap_ready", 32'(st_ready), 32'd1);
    step();
    st_req = 1'b0;
    chk("wrap_count_same", 32'(count), 32'd3);
    chk("wrap_head2",      dm_wdata,   32'h202);
    step();
    chk("wrap_head3", dm_wdata, 32'h203);
    step();
    chk("wrap_head_new", dm_wdata, 32'h300);
    step();
    dm_ready = 1'b0;
    chk("wrap_empty", 32'(count), 32'd0);

    // Flush with three entries
    for (int i = 0; i < 3; i++) push(32'h500 + 32'(4 * i), 32'h500 + 32'(i), 32'h0);
    flush    = 1'b1;
    dm_ready = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_ready_d1", 32'(st_ready),   32'd0);
    chk("fl_count_d1", 32'(count),      32'd2);
    chk("fl_done_d1",  32'(flush_done), 32'd0);
    flush = 1'b1;  // re-assertion in DRAIN has no effect
    step();
    flush = 1'b0;
    chk("fl_ready_d2", 32'(st_ready), 32'd0);
    chk("fl_count_d2", 32'(count),    32'd1);
    step();
    chk("fl_ready_d3", 32'(st_ready),   32'd0);
    chk("fl_count_d3", 32'(count),      32'd0);
    chk("fl_done_d3",  32'(flush_done), 32'd0);
    step();
    chk("fl_done_pulse", 32'(flush_done), 32'd1);
    chk("fl_idle_ready", 32'(st_ready),   32'd1);
    step();
    chk("fl_done_low", 32'(flush_done), 32'd0);
    dm_ready = 1'b0;

    // Flush with empty buffer
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("efl_ready", 32'(st_ready),   32'd0);
    chk("efl_done0", 32'(flush_done), 32'd0);
    step();
    chk("efl_done1", 32'(flush_done), 32'd1);
    step();
    chk("efl_done2", 32'(flush_done), 32'd0);

    // Asynchronous reset mid-cycle discards pending entries
    push(32'h700, 32'h7, 32'h0);
    push(32'h704, 32'h8, 32'h0);
    #1;
    chk("ar_count_pre", 32'(count), 32'd2);
    reset = 1'b1;
    #1;
    chk("ar_count",    32'(count),    32'd0);
    chk("ar_dm_we",    32'(dm_we),    32'd0);
    chk("ar_overflow", 32'(overflow), 32'd0);
    chk("ar_st_ready", 32'(st_ready), 32'd0);
    @(negedge clk);
    reset    = 1'b0;
    dm_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ar_no_write", 32'(dm_we), 32'd0);
    end
    chk("ar_ready_after", 32'(st_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter: DEPTH, default 4, number of buffered store entries (power of two, >=2).
REQ-002 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 Port: st_req  input  1  CPU store request this cycle.
REQ-005 Port: st_addr  input  32  store byte address; bits [1:0] ignored.
REQ-006 Port: st_data  input  32  store word.
REQ-007 Port: st_pc  input  32  PC of the store instruction, carried with the entry.
REQ-008 Port: st_ready  output  1  buffer can accept a store this cycle.
REQ-009 Port: ld_addr  input  32  load byte address for forwarding lookup.
REQ-010 Port: ld_hit  output  1  a buffered store matches ld_addr.
REQ-011 Port: ld_data  output  32  forwarded word, valid when ld_hit=1, else 0.
REQ-012 Port: flush  input  1  request to drain all entries to data memory.
REQ-013 Port: flush_done  output  1  one-cycle pulse when a flush completes.
REQ-014 Port: dm_we  output  1  write request to data memory (head entry valid).
REQ-015 Port: dm_addr / dm_wdata / dm_pc  output  32 each  head entry address {addr[31:2],2'b00}, data, PC.
REQ-016 Port: dm_ready  input  1  data memory accepts the write at this rising edge.
REQ-017 Port: count  output  $clog2(DEPTH)+1  number of valid entries.
REQ-018 Port: overflow  output  1  sticky flag, a store was dropped.

Function
REQ-019 Storage SHALL be an in-order FIFO of DEPTH entries {word address [31:2], data, pc}, with head/tail pointers wrapping modulo DEPTH.
REQ-020 Push SHALL occur at a rising edge when st_req=1 and st_ready=1; entry written at the tail, tail and count advance.
REQ-021 Pop SHALL occur at a rising edge when dm_we=1 and dm_ready=1; head and count advance.
REQ-022 dm_we SHALL equal (count!=0); dm_addr/dm_wdata/dm_pc SHALL show the head entry combinationally, zero when empty.
REQ-023 st_ready SHALL be (count<DEPTH) and state==IDLE; it SHALL NOT depend on dm_ready.
REQ-024 Simultaneous push and pop SHALL leave count unchanged, both pointers advancing; with count=1 the new entry becomes head next cycle.
REQ-025 st_req=1 with st_ready=0 SHALL drop the store, leave FIFO unchanged, and set overflow to 1 until reset.
REQ-026 ld_hit/ld_data SHALL be combinational over current valid entries comparing ld_addr[31:2]; youngest matching entry wins; a store being pushed in the same cycle is not visible.
REQ-027 An entry being popped in the current cycle SHALL still be visible to forwarding in that cycle.
REQ-028 State machine: IDLE, DRAIN. IDLE->DRAIN when flush=1; DRAIN->IDLE when count==0, asserting flush_done for exactly that transition cycle (registered, one cycle high).
REQ-029 flush=1 with count==0 in IDLE SHALL enter DRAIN and return to IDLE next cycle with a single flush_done pulse.
REQ-030 In DRAIN, pops SHALL continue normally, pushes SHALL be refused (st_ready=0; st_req then sets overflow), flush re-asserted SHALL be ignored.
REQ-031 count SHALL never exceed DEPTH nor underflow below 0.

Reset
REQ-032 While reset=1: count=0, head=tail=0, all entries invalid, state=IDLE, overflow=0, flush_done=0, dm_we=0, ld_hit=0, st_ready=0; st_ready=1 from the first cycle after deassertion.
REQ-033 Reset asserted mid-drain or mid-write SHALL discard all pending entries; no dm_we after reset.

Verification
REQ-034 Push 0x10<-0xAAAA0001 with dm_ready=0 -> count=1, dm_we=1, dm_addr=0x10, dm_wdata=0xAAAA0001; raise dm_ready one cycle -> count=0, dm_we=0.
REQ-035 Push 0x20<-1 then 0x20<-2, dm_ready=0, ld_addr=0x23 -> ld_hit=1, ld_data=2; ld_addr=0x24 -> ld_hit=0, ld_data=0.
REQ-036 Fill DEPTH=4 with dm_ready=0 -> st_ready=0; fifth st_req -> overflow=1, count=4; then dm_ready=1 four cycles -> writes in push order, count=0.
REQ-037 count=4, dm_ready=1, st_req=1 in the same cycle -> no push (st_ready=0), count=3; next cycle push and pop together -> count stays 3, pointers wrap past index 3.
REQ-038 Three entries, flush=1 with dm_ready=1 -> st_ready=0 for three drain cycles, flush_done pulses once when count reaches 0, state back to IDLE.
REQ-039 Two entries, assert reset between clock edges -> count=0, dm_we=0 immediately without a clock edge; no pending entry ever written.
